// File: rtl/adder_arbiter_if.sv
// Requester and adder-side signal bundle for adder_arbiter.
// slave: arbiter side; master: requesters plus the adder.
interface adder_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
) ();
    logic [NUM_REQ-1:0]        req_vld;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ-1:0]        req_rdy;
    logic [NUM_REQ-1:0]        rsp_vld;
    logic [DATA_W:0]           rsp_sum;
    logic                      add_vld;
    logic [DATA_W-1:0]         add_a;
    logic [DATA_W-1:0]         add_b;
    logic                      add_out_vld;
    logic [DATA_W:0]           add_sum;
    logic                      err;

    modport slave (
        input  req_vld, req_a, req_b,
        input  add_out_vld, add_sum,
        output req_rdy, rsp_vld, rsp_sum,
        output add_vld, add_a, add_b, err
    );

    modport master (
        output req_vld, req_a, req_b,
        output add_out_vld, add_sum,
        input  req_rdy, rsp_vld, rsp_sum,
        input  add_vld, add_a, add_b, err
    );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin sharing of one adder among NUM_REQ requesters,
// with in-order ID tracking to route each sum back to its source.
// Ports: clk, rst_n (async active-low), bus (adder_arbiter_if.slave).
// Option: ADDER_ARB_PRIO_EN gives requester 0 strict priority.
module adder_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int MAX_OUT = 4
) (
    input logic            clk,
    input logic            rst_n,
    adder_arbiter_if.slave bus
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_OUT + 1);
    localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    logic [IW-1:0]      ptr;
    logic [IW-1:0]      gnt_id;
    logic               gnt;
    logic [NUM_REQ-1:0] rdy;
    logic [CW-1:0]      cnt;
    logic [IW-1:0]      fifo [MAX_OUT];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic               fifo_ne;
    logic               pop;
    logic               credit;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
    endfunction

    // cnt mirrors FIFO occupancy, so it doubles as the empty flag
    assign fifo_ne = (cnt != '0);
    assign pop     = bus.add_out_vld & fifo_ne;
    // a return in this cycle frees a slot for a grant in this cycle
    assign credit  = (cnt < CW'(MAX_OUT)) | bus.add_out_vld;

    always_comb begin
        int idx;
        idx    = 0;
        gnt    = 1'b0;
        gnt_id = '0;
        rdy    = '0;
`ifdef ADDER_ARB_PRIO_EN
        if (credit && bus.req_vld[0]) begin
            gnt = 1'b1;
        end else if (credit) begin
            // rotate over 1..NUM_REQ-1 only
            for (int k = 1; k < NUM_REQ; k++) begin
                idx = ((int'(ptr) - 1 + k) % (NUM_REQ - 1)) + 1;
                if (!gnt && bus.req_vld[idx]) begin
                    gnt    = 1'b1;
                    gnt_id = IW'(idx);
                end
            end
        end
`else
        if (credit) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                idx = (int'(ptr) + k) % NUM_REQ;
                if (!gnt && bus.req_vld[idx]) begin
                    gnt    = 1'b1;
                    gnt_id = IW'(idx);
                end
            end
        end
`endif
        if (gnt) rdy[gnt_id] = 1'b1;
    end

    assign bus.req_rdy = rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= IW'(NUM_REQ - 1);
        end else begin
`ifdef ADDER_ARB_PRIO_EN
            if (gnt && gnt_id != '0) ptr <= gnt_id;
`else
            if (gnt) ptr <= gnt_id;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < MAX_OUT; i++) fifo[i] <= '0;
        end else begin
            if (gnt && !pop)      cnt <= cnt + 1'b1;
            else if (!gnt && pop) cnt <= cnt - 1'b1;
            if (gnt) begin
                fifo[wr_ptr] <= gnt_id;
                wr_ptr       <= inc(wr_ptr);
            end
            if (pop) rd_ptr <= inc(rd_ptr);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.add_vld <= 1'b0;
            bus.add_a   <= '0;
            bus.add_b   <= '0;
        end else begin
            bus.add_vld <= gnt;
            if (gnt) begin
                bus.add_a <= bus.req_a[gnt_id*DATA_W +: DATA_W];
                bus.add_b <= bus.req_b[gnt_id*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rsp_vld <= '0;
            bus.rsp_sum <= '0;
            bus.err     <= 1'b0;
        end else begin
            bus.rsp_vld <= '0;
            if (pop) begin
                bus.rsp_vld <= NUM_REQ'(1) << fifo[rd_ptr];
                bus.rsp_sum <= bus.add_sum;
            end
            // a return with nothing outstanding is sticky
            if (bus.add_out_vld && !fifo_ne) bus.err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter with a behavioural adder.
// Stimulus pushes expected results; a monitor pops on rsp_vld.
module tb_adder_arbiter;
    typedef struct {
        int         id;
        logic [8:0] sum;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    exp_t       sb [$];
    logic [8:0] pipe [$];
    exp_t       e;

    int         auto_rel = 1;
    int         rel_budget = 0;
    bit         inject = 1'b0;
    logic [8:0] inj_sum = 9'h055;

    logic [7:0] va [4] = '{8'h10, 8'hFF, 8'h80, 8'h7F};
    logic [7:0] vb [4] = '{8'h05, 8'h01, 8'h80, 8'h01};
    logic [8:0] vs [4] = '{9'h015, 9'h100, 9'h100, 9'h080};

    adder_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) bus ();

    adder_arbiter #(
        .NUM_REQ(4),
        .DATA_W(8),
        .MAX_OUT(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || pipe.size() != 0) && n < 40) begin
            tick();
            n++;
        end
        total++;
        if (sb.size() != 0 || pipe.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
    endtask

    // behavioural adder: latency 1, optional hold / spurious return
    always @(posedge clk) begin
        #1;
        bus.add_out_vld = 1'b0;
        if (!rst_n) begin
            pipe.delete();
            bus.add_sum = '0;
        end else begin
            if (inject) begin
                bus.add_out_vld = 1'b1;
                bus.add_sum     = inj_sum;
                inject          = 1'b0;
            end else if (pipe.size() > 0 &&
                         (auto_rel != 0 || rel_budget > 0)) begin
                bus.add_out_vld = 1'b1;
                bus.add_sum     = pipe.pop_front();
                if (auto_rel == 0) rel_budget--;
            end
            if (bus.add_vld)
                pipe.push_back({1'b0, bus.add_a} + {1'b0, bus.add_b});
        end
    end

    // response monitor
    always @(posedge clk) begin
        #1;
        if (rst_n && bus.rsp_vld != '0) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rsp_unexpected: got %b want none",
                         bus.rsp_vld);
            end else begin
                e = sb.pop_front();
                chk("rsp_vld", 32'(bus.rsp_vld), 32'(1) << e.id);
                chk("rsp_sum", 32'(bus.rsp_sum), 32'(e.sum));
            end
        end
    end

    initial begin
        int ord3 [6] = '{0, 1, 2, 3, 0, 1};
        int ord4 [4] = '{2, 3, 0, 1};
        bus.req_vld = '0;
        for (int i = 0; i < 4; i++) begin
            bus.req_a[i*8 +: 8] = va[i];
            bus.req_b[i*8 +: 8] = vb[i];
        end
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_add_vld", 32'(bus.add_vld), 0);
        chk("rst_rsp_vld", 32'(bus.rsp_vld), 0);
        chk("rst_err", 32'(bus.err), 0);
        rst_n = 1'b1;
        tick();

        // single requester, carry out of the 8-bit range
        bus.req_vld = 4'b0010;
        #1;
        chk("t2_rdy", 32'(bus.req_rdy), 32'h2);
        sb.push_back('{1, 9'h100});
        tick();
        bus.req_vld = '0;
        chk("t2_add_vld", 32'(bus.add_vld), 1);
        chk("t2_add_a", 32'(bus.add_a), 32'hFF);
        chk("t2_add_b", 32'(bus.add_b), 32'h01);
        drain();

        // reset with an operation in flight
        bus.req_vld = 4'b0001;
        #1;
        chk("t1_rdy", 32'(bus.req_rdy), 32'h1);
        tick();
        bus.req_vld = '0;
        chk("t1_inflight", 32'(bus.add_vld), 1);
        rst_n = 1'b0;
        #1;
        chk("t1_add_vld", 32'(bus.add_vld), 0);
        chk("t1_add_a", 32'(bus.add_a), 0);
        chk("t1_rsp_vld", 32'(bus.rsp_vld), 0);
        chk("t1_rsp_sum", 32'(bus.rsp_sum), 0);
        chk("t1_err", 32'(bus.err), 0);
        sb.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();

`ifndef ADDER_ARB_PRIO_EN
        // all requesting: rotation starts at 0
        bus.req_vld = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("t3_rdy%0d", i), 32'(bus.req_rdy),
                32'(1) << ord3[i]);
            sb.push_back('{ord3[i], vs[ord3[i]]});
            tick();
        end
        bus.req_vld = '0;
        drain();

        // adder holds results: credit runs out at MAX_OUT
        auto_rel = 0;
        rel_budget = 0;
        bus.req_vld = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (i < 4) begin
                chk($sformatf("t4_rdy%0d", i), 32'(bus.req_rdy),
                    32'(1) << ord4[i]);
                sb.push_back('{ord4[i], vs[ord4[i]]});
            end else begin
                chk($sformatf("t4_stall%0d", i), 32'(bus.req_rdy), 0);
            end
            tick();
        end
        rel_budget = 1;
        tick();
        #1;
        chk("t4_ret_gnt", 32'(bus.req_rdy), 32'h4);
        sb.push_back('{2, vs[2]});
        tick();
        #1;
        chk("t4_full_again", 32'(bus.req_rdy), 0);
        bus.req_vld = '0;
        auto_rel = 1;
        drain();
`else
        // requester 0 strict priority
        bus.req_vld = 4'b0101;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("t6_rdy%0d", i), 32'(bus.req_rdy), 32'h1);
            sb.push_back('{0, vs[0]});
            tick();
        end
        bus.req_vld = 4'b0100;
        #1;
        chk("t6_rdy_r2", 32'(bus.req_rdy), 32'h4);
        sb.push_back('{2, vs[2]});
        tick();
        bus.req_vld = '0;
        drain();
`endif

        // spurious adder return
        chk("t5_err_pre", 32'(bus.err), 0);
        inject = 1'b1;
        tick();
        tick();
        chk("t5_err", 32'(bus.err), 1);
        chk("t5_rsp_vld", 32'(bus.rsp_vld), 0);
        repeat (3) tick();
        chk("t5_err_sticky", 32'(bus.err), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
